// File: rtl/crop_stream_arbiter.sv
// crop_stream_arbiter: round-robin arbiter that locks one crop stream per PKT_LEN-beat packet.
// Defining CROP_ARB_LAST_EN adds out_last, which marks the final beat of each packet.
module crop_stream_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int PKT_LEN = 9,
  localparam int SW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(PKT_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SW-1:0]                 out_src,
  output logic                          busy
`ifdef CROP_ARB_LAST_EN
  ,
  output logic                          out_last
`endif
);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] grant_q, grant_d, rr_q, rr_d, pick, idx;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic locked, beat, last;
  assign locked    = state_q == LOCKED;
  assign out_valid = locked & req_valid[grant_q];
  assign out_data  = locked ? req_data[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign req_ready = (locked & out_ready) ? (NUM_REQ'(1) << grant_q) : '0;
  assign out_src   = locked ? grant_q : '0;
  assign busy      = locked;
  assign beat      = out_valid & out_ready;
  assign last      = beat_cnt_q == CW'(PKT_LEN - 1);
`ifdef CROP_ARB_LAST_EN
  assign out_last  = out_valid & last;
`endif
  // Scan downward so the requester closest to rr_q wins.
  always_comb begin
    pick = rr_q;
    idx  = rr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = SW'((int'(rr_q) + i) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    if (!locked) begin
      if (|req_valid) begin
        state_d = LOCKED;
        grant_d = pick;
      end
    end else if (beat) begin
      beat_cnt_d = last ? '0 : beat_cnt_q + CW'(1);
      if (last) begin
        state_d = IDLE;
        rr_d    = SW'((int'(grant_q) + 1) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: doc/crop_stream_arbiter.md
CROP_STREAM_ARBITER -- requirements
Module: crop_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel word width in bits.
REQ-002 Parameter NUM_REQ, default 4: number of crop-stream requesters, 1..16.
REQ-003 Parameter PKT_LEN, default 9: beats per crop packet (OUT_ROWS*OUT_COLS), >=1.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1: reset, asynchronous and active-low.
REQ-006 Port req_valid  input  NUM_REQ: per-requester data valid.
REQ-007 Port req_ready  output  NUM_REQ: per-requester accept.
REQ-008 Port req_data  input  NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port out_valid  output  1: valid toward the shared first-word-fall-through FIFO write side.
REQ-010 Port out_ready  input  1: FIFO in_ready.
REQ-011 Port out_data  output  DATA_WIDTH: word to FIFO.
REQ-012 Port out_src  output  max(1,$clog2(NUM_REQ)): index of the granted requester.
REQ-013 Port busy  output  1: high while a packet is locked.

Function
REQ-014 The block SHALL implement two states, IDLE and LOCKED, with a registered grant index, round-robin pointer rr_ptr, and beat counter beat_cnt of width $clog2(PKT_LEN+1).
REQ-015 In IDLE, when any req_valid is high, the block SHALL latch grant = the first index with req_valid high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ, and enter LOCKED on the next edge.
REQ-016 In IDLE, out_valid, all req_ready, busy and out_src SHALL be 0.
REQ-017 In LOCKED, out_valid = req_valid[grant], out_data = req_data[grant], req_ready[grant] = out_ready, and all other req_ready = 0, all combinational (zero added latency).
REQ-018 A beat SHALL count only when out_valid and out_ready are both high in LOCKED.
REQ-019 On the beat where beat_cnt == PKT_LEN-1, the block SHALL clear beat_cnt, set rr_ptr = (grant+1) mod NUM_REQ, and return to IDLE.
REQ-020 Each packet boundary SHALL therefore cost exactly one idle cycle; sustained throughput is PKT_LEN/(PKT_LEN+1) beats per cycle.
REQ-021 If req_valid[grant] drops mid-packet, the grant SHALL be held, with out_valid low and no rotation, until the packet completes.
REQ-022 If out_ready is low (FIFO full), out_data and out_valid SHALL stay stable and beat_cnt SHALL hold.
REQ-023 Requesters asserting valid while another is locked SHALL be ignored until IDLE, with no starvation: each waiting requester is granted within NUM_REQ packets.
REQ-024 With PKT_LEN=1, each beat SHALL form a full packet; with NUM_REQ=1, rr_ptr SHALL stay 0.
REQ-025 busy SHALL equal (state == LOCKED); out_src SHALL equal grant in LOCKED and 0 in IDLE.

Reset
REQ-026 On reset_n low, the block SHALL asynchronously force state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, so every output reads 0.
REQ-027 A reset asserted mid-packet SHALL abandon the partial packet; after release, arbitration SHALL restart from requester 0.

Configuration
REQ-028 With macro CROP_ARB_LAST_EN defined, the block SHALL add an output port out_last (1 bit), high when out_valid is high and beat_cnt == PKT_LEN-1, and 0 otherwise and during reset.
REQ-029 Without CROP_ARB_LAST_EN, the out_last port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Single requester: NUM_REQ=4, PKT_LEN=9, only req 2 streams 0..17 with out_ready=1 -> two packets with out_src=2, data 0..17 in order, and one bubble cycle between beats 8 and 9.
REQ-031 Round-robin: all four requests held valid -> grant order 0,1,2,3,0, with 9 beats each.
REQ-032 Backpressure: random out_ready and random req_valid for 200 cycles -> no lost or duplicated word per source, and no packet interleaving on out_src.
REQ-033 Mid-packet reset: reset_n pulsed low at beat 4 of req 1's packet -> outputs go to 0 immediately, and the next grant goes to the lowest valid index starting from 0.
REQ-034 Boundary: PKT_LEN=1, reqs 0 and 3 valid -> alternating grants 0,3,0,3 with one beat each.
REQ-035 CROP_ARB_LAST_EN defined: out_last is high exactly on the 9th accepted beat of each packet, and on no other cycle.
